// File: rtl/dsm_sample_scheduler_pkg.sv
// Shared types and constants for the DSM sample scheduler: FSM states,
// rate codes, nominal sample periods and the period classifier.
package dsm_sched_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} sched_state_e;

    typedef enum logic [1:0] {
        RATE_1X   = 2'd0,
        RATE_2X   = 2'd1,
        RATE_4X   = 2'd2,
        RATE_NONE = 2'd3
    } rate_code_e;

    localparam int PER_1X       = 1024;
    localparam int PER_2X       = 512;
    localparam int PER_4X       = 256;
    localparam int SCHED_DATA_W = 32;

    typedef struct packed {
        logic [SCHED_DATA_W-1:0] l;
        logic [SCHED_DATA_W-1:0] r;
    } stereo_frame_t;

    // Windows are inclusive on both ends.
    function automatic rate_code_e classify(input logic [10:0] p, input int tol);
        int pi;
        pi = {21'd0, p};
        if (pi >= PER_1X - tol && pi <= PER_1X + tol) return RATE_1X;
        if (pi >= PER_2X - tol && pi <= PER_2X + tol) return RATE_2X;
        if (pi >= PER_4X - tol && pi <= PER_4X + tol) return RATE_4X;
        return RATE_NONE;
    endfunction

endpackage

// File: rtl/dsm_sample_scheduler_frame_fifo.sv
// Stereo frame FIFO with synchronous flush. On a simultaneous push/pop into a
// full FIFO the pop frees the slot first, so the push is accepted.
module stereo_frame_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok, push_ok;

    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (cnt_q != CW'(DEPTH) || pop_ok);
    assign drop_o  = push_i && !push_ok && !flush_i;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/dsm_sample_scheduler.sv
// I2S-to-DSM sample scheduler: rate lock, L/R framing, frame FIFO and req/ack
// serving. Define SCHED_HOLD_LAST_EN to repeat the last frame on underrun.
module dsm_sample_scheduler
    import dsm_sched_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LOCK_CNT   = 4,
    parameter int TOL        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_l_i,
    input  logic              data_l_stb_i,
    input  logic [DATA_W-1:0] data_r_i,
    input  logic              data_r_stb_i,
    input  logic              dsd_mode_i,
    input  logic              sample_req_i,
    output logic              sample_ack_o,
    output logic [DATA_W-1:0] out_l_o,
    output logic [DATA_W-1:0] out_r_o,
    output logic [1:0]        rate_code_o,
    output logic              locked_o,
    output logic              mute_o,
    output logic              underrun_o,
    output logic              overflow_o
);
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam int FW  = 2 * DATA_W;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic              started_q, started_d;
    logic [10:0]       per_cnt_q, per_cnt_d;
    rate_code_e        prev_code_q, prev_code_d, meas_code, rate_q, rate_d;
    logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;

    sched_state_e      state_q, state_d;
    logic              pend_q;
    logic [DATA_W-1:0] held_l_q;
    logic              ack_q, underrun_q, overflow_q, mute_q;
    logic [FW-1:0]     out_q, hold_frame, ack_frame;

    logic [FW-1:0]     fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_drop, fifo_push, fifo_pop, fifo_flush;
    logic              force_idle, run_req, underrun;

    assign meas_code = classify(per_cnt_q, TOL);

    always_comb begin
        started_d   = started_q;
        per_cnt_d   = (per_cnt_q == 11'h7FF) ? per_cnt_q : per_cnt_q + 11'd1;
        prev_code_d = prev_code_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        rate_d      = rate_q;
        if (data_l_stb_i) begin
            per_cnt_d = '0;
            started_d = 1'b1;
            if (started_q) begin
                prev_code_d = meas_code;
                if (meas_code != RATE_NONE && meas_code == prev_code_q) begin
                    lock_cnt_d = (lock_cnt_q >= LCW'(LOCK_CNT)) ? lock_cnt_q : lock_cnt_q + LCW'(1);
                    if (lock_cnt_d >= LCW'(LOCK_CNT)) begin
                        locked_d = 1'b1;
                        rate_d   = meas_code;
                    end
                end else begin
                    locked_d   = 1'b0;
                    rate_d     = RATE_NONE;
                    lock_cnt_d = (meas_code != RATE_NONE) ? LCW'(1) : '0;
                end
            end
        end else if (started_q && per_cnt_q == 11'h7FF) begin
            // Strobes stopped: drop lock and forget the last class.
            locked_d    = 1'b0;
            rate_d      = RATE_NONE;
            lock_cnt_d  = '0;
            prev_code_d = RATE_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started_q   <= 1'b0;
            per_cnt_q   <= '0;
            prev_code_q <= RATE_NONE;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            rate_q      <= RATE_NONE;
        end else begin
            started_q   <= started_d;
            per_cnt_q   <= per_cnt_d;
            prev_code_q <= prev_code_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            rate_q      <= rate_d;
        end
    end

    assign force_idle = !locked_q || dsd_mode_i;
    assign fifo_flush = force_idle || state_q == IDLE;
    assign fifo_push  = data_r_stb_i && pend_q;
    assign run_req    = sample_req_i && state_q == RUN;
    assign underrun   = run_req && fifo_empty;
    assign fifo_pop   = run_req && !fifo_empty;

    always_comb begin
        state_d = state_q;
        if (force_idle) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = FILL;
                FILL:    if (fifo_count >= CW'(FIFO_DEPTH / 2)) state_d = RUN;
                RUN:     if (underrun) state_d = FILL;
                default: state_d = IDLE;
            endcase
        end
    end

    stereo_frame_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .din_i   ({held_l_q, data_r_i}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

`ifdef SCHED_HOLD_LAST_EN
    logic [FW-1:0] last_q;
    always_ff @(posedge clk) begin
        if (rst || state_d == IDLE) last_q <= '0;
        else if (fifo_pop)          last_q <= fifo_dout;
    end
    assign hold_frame = last_q;
`else
    assign hold_frame = '0;
`endif

    assign ack_frame = fifo_pop ? fifo_dout : (underrun ? hold_frame : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            held_l_q   <= '0;
            ack_q      <= 1'b0;
            out_q      <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            mute_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            // A same-cycle L strobe re-arms pending after the R strobe paired.
            if (data_l_stb_i) begin
                held_l_q <= data_l_i;
                pend_q   <= 1'b1;
            end else if (fifo_push) begin
                pend_q   <= 1'b0;
            end
            ack_q      <= sample_req_i;
            if (sample_req_i) out_q <= ack_frame;
            underrun_q <= underrun;
            overflow_q <= fifo_drop;
            mute_q     <= (state_d != RUN);
        end
    end

    assign sample_ack_o = ack_q;
    assign out_l_o      = out_q[FW-1:DATA_W];
    assign out_r_o      = out_q[DATA_W-1:0];
    assign rate_code_o  = rate_q;
    assign locked_o     = locked_q;
    assign mute_o       = mute_q;
    assign underrun_o   = underrun_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_dsm_sample_scheduler.sv
// Directed bench for dsm_sample_scheduler: frames are queued on push and
// compared against served acks.
module tb_dsm_sample_scheduler;
    import dsm_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_l_i = '0, data_r_i = '0;
    logic        data_l_stb_i = 1'b0, data_r_stb_i = 1'b0;
    logic        dsd_mode_i = 1'b0, sample_req_i = 1'b0;
    logic        sample_ack_o, locked_o, mute_o, underrun_o, overflow_o;
    logic [31:0] out_l_o, out_r_o;
    logic [1:0]  rate_code_o;

    int total = 0;
    int bad   = 0;
    int pc    = 0;
    stereo_frame_t sb[$];
    stereo_frame_t last = '0;

    dsm_sample_scheduler #(.DATA_W(32), .FIFO_DEPTH(4), .LOCK_CNT(4), .TOL(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_l_i     (data_l_i),
        .data_l_stb_i (data_l_stb_i),
        .data_r_i     (data_r_i),
        .data_r_stb_i (data_r_stb_i),
        .dsd_mode_i   (dsd_mode_i),
        .sample_req_i (sample_req_i),
        .sample_ack_o (sample_ack_o),
        .out_l_o      (out_l_o),
        .out_r_o      (out_r_o),
        .rate_code_o  (rate_code_o),
        .locked_o     (locked_o),
        .mute_o       (mute_o),
        .underrun_o   (underrun_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pc++;
    endtask

    // L strobe, 3 idle cycles, then an R strobe (or idle): 5 cycles total.
    task automatic start_period(input logic [31:0] l, input logic [31:0] r, input bit with_r,
                                input bit push_exp, input bit ovf_exp);
        pc = 0;
        data_l_i = l; data_l_stb_i = 1'b1; tick(); data_l_stb_i = 1'b0;
        repeat (3) tick();
        if (with_r) begin
            data_r_i = r; data_r_stb_i = 1'b1; tick(); data_r_stb_i = 1'b0;
            chk("overflow", 64'(overflow_o), ovf_exp ? 64'd1 : 64'd0);
            if (push_exp) sb.push_back('{l: l, r: r});
        end else begin
            tick();
        end
    endtask

    task automatic end_period(input int p);
        while (pc < p) tick();
        chk("ack_idle", 64'(sample_ack_o), 64'd0);
    endtask

    task automatic period(input int p, input logic [31:0] l, input logic [31:0] r,
                          input bit with_r, input bit push_exp);
        start_period(l, r, with_r, push_exp, 1'b0);
        end_period(p);
    endtask

    // mode 0: muted ack, 1: next queued frame, 2: underrun
    task automatic do_req(input int mode);
        logic [63:0] exp;
        sample_req_i = 1'b1; tick(); sample_req_i = 1'b0;
        chk("ack", 64'(sample_ack_o), 64'd1);
        exp = '0;
        if (mode == 1) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard: request with no expected frame");
            end else begin
                last = sb.pop_front();
                exp  = last;
            end
        end else if (mode == 2) begin
`ifdef SCHED_HOLD_LAST_EN
            exp = last;
`else
            exp = '0;
`endif
        end
        chk("frame", {out_l_o, out_r_o}, exp);
        chk("underrun", 64'(underrun_o), (mode == 2) ? 64'd1 : 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 64'(sample_ack_o), 64'd0);
        chk({tag, "_out"}, {out_l_o, out_r_o}, 64'd0);
        chk({tag, "_rate"}, 64'(rate_code_o), 64'd3);
        chk({tag, "_locked"}, 64'(locked_o), 64'd0);
        chk({tag, "_mute"}, 64'(mute_o), 64'd1);
        chk({tag, "_underrun"}, 64'(underrun_o), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow_o), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Lock at 1x: first strobe starts the counter, 4 in-class periods lock.
        for (int i = 0; i < 4; i++) period(1024, 32'h100 + i, 0, 1'b0, 1'b0);
        chk("lock_pre", 64'(locked_o), 64'd0);
        period(1024, 32'h104, 0, 1'b0, 1'b0);
        chk("lock_1x", 64'(locked_o), 64'd1);
        chk("rate_1x", 64'(rate_code_o), 64'd0);
        chk("mute_fill", 64'(mute_o), 64'd1);
        period(1024, 32'hA001, 32'hB001, 1'b1, 1'b1);
        chk("mute_fill1", 64'(mute_o), 64'd1);
        period(1024, 32'hA002, 32'hB002, 1'b1, 1'b1);
        chk("mute_run", 64'(mute_o), 64'd0);

        // Back-to-back pops, then underrun on the drained FIFO.
        start_period(32'hA003, 32'hB003, 1'b1, 1'b1, 1'b0);
        do_req(1); do_req(1);
        end_period(1024);
        start_period(32'hA009, 0, 1'b0, 1'b0, 1'b0);
        do_req(1); do_req(2);
        chk("mute_underrun", 64'(mute_o), 64'd1);
        end_period(1024);

        // Five pushes into a depth-4 FIFO: the fifth is dropped.
        for (int i = 1; i <= 4; i++) period(1024, 32'hC000 + i, 32'hD000 + i, 1'b1, 1'b1);
        start_period(32'hC005, 32'hD005, 1'b1, 1'b0, 1'b1);
        end_period(1024);
        start_period(32'hAAAA, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_req(1);
        end_period(1024);

        // Same-cycle L/R pairs R with held L; lone R without pending is dropped.
        pc = 0;
        data_l_i = 32'hBBBB; data_r_i = 32'hCCCC;
        data_l_stb_i = 1'b1; data_r_stb_i = 1'b1; tick();
        data_l_stb_i = 1'b0; data_r_stb_i = 1'b0;
        sb.push_back('{l: 32'hAAAA, r: 32'hCCCC});
        repeat (3) tick();
        data_r_i = 32'hDDDD; data_r_stb_i = 1'b1; tick(); data_r_stb_i = 1'b0;
        sb.push_back('{l: 32'hBBBB, r: 32'hDDDD});
        data_r_i = 32'hEEEE; data_r_stb_i = 1'b1; tick(); data_r_stb_i = 1'b0;
        do_req(1); do_req(1); do_req(2);
        end_period(1024);

        // DSD mid-RUN: IDLE next cycle, muted acks, buffered frames flushed.
        period(1024, 32'hE001, 32'hF001, 1'b1, 1'b1);
        period(1024, 32'hE002, 32'hF002, 1'b1, 1'b1);
        chk("mute_run2", 64'(mute_o), 64'd0);
        start_period(32'hE003, 32'hF003, 1'b1, 1'b0, 1'b0);
        dsd_mode_i = 1'b1; tick();
        chk("mute_dsd", 64'(mute_o), 64'd1);
        sb.delete(); last = '0;
        do_req(0);
        dsd_mode_i = 1'b0;
        end_period(1024);
        chk("lock_dsd", 64'(locked_o), 64'd1);
        period(1024, 32'h5001, 32'h6001, 1'b1, 1'b1);
        period(1024, 32'h5002, 32'h6002, 1'b1, 1'b1);
        start_period(32'h5003, 0, 1'b0, 1'b0, 1'b0);
        do_req(1);
        end_period(1024);

        // Rate change to 2x: unlock, relock after 4 in-class periods.
        period(512, 32'h7000, 0, 1'b0, 1'b0);
        period(512, 32'h7001, 0, 1'b0, 1'b0);
        chk("unlock_2x", 64'(locked_o), 64'd0);
        chk("rate_none", 64'(rate_code_o), 64'd3);
        sb.delete(); last = '0;
        period(512, 32'h7002, 0, 1'b0, 1'b0);
        period(512, 32'h7003, 0, 1'b0, 1'b0);
        chk("lock_pre_2x", 64'(locked_o), 64'd0);
        period(512, 32'h7004, 32'h8004, 1'b1, 1'b0);
        chk("lock_2x", 64'(locked_o), 64'd1);
        chk("rate_2x", 64'(rate_code_o), 64'd1);
        period(1040, 32'h7005, 32'h8005, 1'b1, 1'b0);
        chk("mute_run_2x", 64'(mute_o), 64'd0);

        // Off-class period while in RUN: unlock next cycle, IDLE one later.
        pc = 0;
        data_l_i = 32'h7006; data_l_stb_i = 1'b1; tick(); data_l_stb_i = 1'b0;
        chk("unlock_off", 64'(locked_o), 64'd0);
        chk("rate_off", 64'(rate_code_o), 64'd3);
        chk("mute_pre_idle", 64'(mute_o), 64'd0);
        tick();
        chk("mute_idle", 64'(mute_o), 64'd1);
        end_period(1040);
        period(1024, 32'h7007, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) period(1024, 32'h7010 + i, 0, 1'b0, 1'b0);
        chk("relock_pre", 64'(locked_o), 64'd0);
        period(1024, 32'h7013, 0, 1'b0, 1'b0);
        chk("relock", 64'(locked_o), 64'd1);
        chk("relock_rate", 64'(rate_code_o), 64'd0);

        // Reset mid-RUN right after an ack.
        period(1024, 32'h9001, 32'h9101, 1'b1, 1'b1);
        period(1024, 32'h9002, 32'h9102, 1'b1, 1'b1);
        start_period(32'h9003, 0, 1'b0, 1'b0, 1'b0);
        do_req(1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outputs("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
